// File: rtl/pattern_sync_pkg.sv
// pattern_sync_pkg: shared state encoding and default constants for pattern_sync_detector
package pattern_sync_pkg;
   typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;
   localparam logic [31:0] DEFAULT_PATTERN = 32'hAABBCCDD;
   localparam int DEFAULT_MISS_MAX = 2;
endpackage

// File: rtl/pattern_window.sv
// pattern_window: sliding symbol window with fill count and combinational post-shift pattern compare
module pattern_window
   import pattern_sync_pkg::*;
#(
   parameter int SYM_W = 8,
   parameter int PAT_SYMS = 4,
   parameter logic [SYM_W*PAT_SYMS-1:0] PATTERN = DEFAULT_PATTERN
) (
   input  logic             CLK,
   input  logic             RSTn,
   input  logic             clear,
   input  logic             data_valid,
   input  logic [SYM_W-1:0] in,
   output logic             win_match
);
   localparam int W = SYM_W * PAT_SYMS;
   localparam int FW = $clog2(PAT_SYMS + 1);
   localparam logic [FW-1:0] FULL = FW'(PAT_SYMS);
   localparam logic [FW-1:0] FILL_MIN = FW'(PAT_SYMS - 1);
   logic [W-1:0] win;
   logic [W-1:0] win_nxt;
   logic [FW-1:0] fill;
   assign win_nxt = {win[W-SYM_W-1:0], in};
   assign win_match = data_valid && (fill >= FILL_MIN) && (win_nxt == PATTERN);
   // shift the newest symbol into the LS position and count fill up to a full window
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         win  <= '0;
         fill <= '0;
      end else if (clear) begin
         win  <= '0;
         fill <= '0;
      end else if (data_valid) begin
         win  <= win_nxt;
         fill <= (fill == FULL) ? fill : fill + 1'b1;
      end
   end
endmodule

// File: rtl/pattern_sync_detector.sv
// pattern_sync_detector: period-aligned pattern lock detector; optional match_total counter under PATTERN_SYNC_DETECTOR_MATCH_CNT_EN
module pattern_sync_detector
   import pattern_sync_pkg::*;
#(
   parameter int SYM_W = 8,
   parameter int PAT_SYMS = 4,
   parameter logic [SYM_W*PAT_SYMS-1:0] PATTERN = DEFAULT_PATTERN,
   parameter int CNT_W = 8,
   parameter int MISS_MAX = DEFAULT_MISS_MAX
) (
   input  logic             CLK,
   input  logic             RSTn,
   input  logic             clear,
   input  logic             data_valid,
   input  logic [SYM_W-1:0] in,
   input  logic [CNT_W-1:0] n,
   output logic             pattern_detected,
   output logic             match_pulse,
   output logic             frame_start,
   output logic [15:0]      match_total
);
   localparam int PW = $clog2(PAT_SYMS);
   localparam int MW = $clog2(MISS_MAX + 1);
   localparam logic [PW-1:0] LAST = PW'(PAT_SYMS - 1);
   localparam logic [MW-1:0] MLAST = MW'(MISS_MAX - 1);
   state_t state;
   logic [CNT_W-1:0] rep_cnt;
   logic [CNT_W-1:0] rep_inc;
   logic [CNT_W-1:0] n_eff;
   logic [PW-1:0] phase;
   logic [MW-1:0] miss_cnt;
   logic win_match;
   logic adv;
   logic period_end;
   pattern_window #(
      .SYM_W(SYM_W),
      .PAT_SYMS(PAT_SYMS),
      .PATTERN(PATTERN)
   ) u_window (
      .CLK(CLK),
      .RSTn(RSTn),
      .clear(clear),
      .data_valid(data_valid),
      .in(in),
      .win_match(win_match)
   );
   assign adv = data_valid && !clear;
   assign n_eff = (n == '0) ? CNT_W'(1) : n;
   assign rep_inc = (rep_cnt == '1) ? rep_cnt : rep_cnt + 1'b1;
   assign period_end = (state != SEARCH) && (phase == LAST);
   assign match_pulse = adv && win_match && ((state == SEARCH) || period_end);
   assign frame_start = adv && (state == LOCKED) && (phase == '0);
   // acquire, track and hold period alignment; lock flag follows the registered state
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state            <= SEARCH;
         rep_cnt          <= '0;
         phase            <= '0;
         miss_cnt         <= '0;
         pattern_detected <= 1'b0;
      end else if (clear) begin
         state            <= SEARCH;
         rep_cnt          <= '0;
         phase            <= '0;
         miss_cnt         <= '0;
         pattern_detected <= 1'b0;
      end else if (data_valid) begin
         phase <= ((state == SEARCH) || (phase == LAST)) ? '0 : phase + 1'b1;
         case (state)
            SEARCH: if (win_match) begin
               rep_cnt          <= CNT_W'(1);
               state            <= (n_eff == CNT_W'(1)) ? LOCKED : TRACK;
               pattern_detected <= (n_eff == CNT_W'(1));
            end
            TRACK: if (period_end) begin
               if (win_match) begin
                  rep_cnt <= rep_inc;
                  if (rep_inc >= n_eff) begin
                     state            <= LOCKED;
                     pattern_detected <= 1'b1;
                  end
               end else begin
                  state   <= SEARCH;
                  rep_cnt <= '0;
               end
            end
            LOCKED: if (period_end) begin
               if (win_match) miss_cnt <= '0;
               else if (miss_cnt == MLAST) begin
                  state            <= SEARCH;
                  rep_cnt          <= '0;
                  miss_cnt         <= '0;
                  pattern_detected <= 1'b0;
               end else miss_cnt <= miss_cnt + 1'b1;
            end
            default: state <= SEARCH;
         endcase
      end
   end
`ifdef PATTERN_SYNC_DETECTOR_MATCH_CNT_EN
   // saturating count of every counted occurrence
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) match_total <= '0;
      else if (clear) match_total <= '0;
      else if (match_pulse && (match_total != 16'hFFFF)) match_total <= match_total + 16'd1;
   end
`else
   assign match_total = 16'h0000;
`endif
endmodule

// File: doc/pattern_sync_detector.md
Name: pattern_sync_detector

Overview:
- Parametrised successor of the team's fixed 4-byte pattern detector.
- Searches a symbol stream for a PAT_SYMS-symbol pattern using a sliding (non-aligned) window.
- Declares lock after n consecutive back-to-back, period-aligned occurrences; tracks alignment while locked and drops lock after MISS_MAX consecutive missed periods.
- Sits after the PRBS/frame-source path, ahead of checker logic, and supplies frame alignment plus a lock flag.

Parameters:
- SYM_W, 8, bits per symbol.
- PAT_SYMS, 4, pattern length in symbols (>=2).
- PATTERN, 32'hAABBCCDD, pattern of width SYM_W*PAT_SYMS. The MS symbol is received first.
- CNT_W, 8, width of n and of the repetition counter.
- MISS_MAX, 2, consecutive missed periods in LOCKED before lock is lost (>=1).

Ports:
- CLK  input  1  clock.
- RSTn  input  1  reset, asynchronous, active-low.
- clear  input  1  synchronous clear to reset state; has priority over data_valid.
- data_valid  input  1  in carries a valid symbol this cycle.
- in  input  SYM_W  incoming symbol.
- n  input  CNT_W  consecutive occurrences required for lock; 0 is treated as 1. Sampled on every use.
- pattern_detected  output  1  lock flag (level).
- match_pulse  output  1  one-cycle pulse for every pattern occurrence that the FSM counts.
- frame_start  output  1  one-cycle pulse while LOCKED on the valid cycle that carries the first symbol of a period.
- match_total  output  16  total matched periods. Only meaningful with the optional feature enabled.

Behaviour:
- Clock and reset: one clock, CLK. Reset RSTn is asynchronous, active-low. Reset and clear produce identical state.
- Reset/clear state:
  - All outputs are 0.
  - Window contents are 0, with fill count 0.
  - State is SEARCH; rep_cnt, phase and miss_cnt are 0.
- Window:
  - On each data_valid cycle, in shifts into the LS symbol position.
  - fill saturates at PAT_SYMS.
  - win_match is combinational, evaluated on the post-shift value: (fill incl. this symbol >= PAT_SYMS) && window == PATTERN.
- Stall: data_valid=0 holds every register (window, state, counters). This is gap tolerant and does not reset. Pulses are 0 on stall cycles.
- FSM, advancing only on data_valid cycles:
  - SEARCH: sliding check on every symbol.
    - win_match with effective n==1 -> LOCKED, rep_cnt=1.
    - win_match with n>1 -> TRACK, rep_cnt=1.
    - In both cases phase=0 and match_pulse=1 on that cycle.
  - TRACK: phase counts 0..PAT_SYMS-1. At phase==PAT_SYMS-1 (period end):
    - win_match -> rep_cnt+1 and match_pulse=1. Go to LOCKED if rep_cnt+1 >= n, else stay in TRACK.
    - No match -> SEARCH, rep_cnt=0. The window is retained, so sliding search resumes on the next symbol; the mismatching symbol itself is not re-evaluated as a sliding match.
  - LOCKED: pattern_detected=1 (registered, asserted the cycle after the transition). frame_start=1 when phase==0 and data_valid. At period end:
    - win_match -> miss_cnt=0, match_pulse=1.
    - No match -> miss_cnt+1. When miss_cnt+1 == MISS_MAX: go to SEARCH, pattern_detected=0 next cycle, rep_cnt=0.
- Latency: pattern_detected rises 1 cycle after the valid cycle carrying the last symbol of the n-th occurrence.
- rep_cnt saturates at all-ones and never wraps. If n is lowered mid-TRACK so that rep_cnt >= n, lock is taken at the next matching period end.
- clear and data_valid in the same cycle: clear wins and the symbol is discarded.
- Overlapping occurrences (e.g. pattern AAAA on an AAAAAA stream) are counted only on period boundaries once in TRACK/LOCKED.

Optional Feature:
- Macro: PATTERN_SYNC_DETECTOR_MATCH_CNT_EN.
- Defined: match_total is a 16-bit counter that increments on every match_pulse, saturates at 16'hFFFF, and is cleared by reset or clear.
- Undefined: no counter logic; match_total is tied to 16'h0000.

Decomposition:
- Package pattern_sync_pkg:
  - state enum (SEARCH, TRACK, LOCKED).
  - default PATTERN constant and DEFAULT_MISS_MAX.
- One sub-module, pattern_window: the shift register, fill counter and win_match comparator, parametrised by SYM_W, PAT_SYMS and PATTERN. The FSM, counters and outputs live in pattern_sync_detector.

Test Plan:
- Lock on 3 repetitions: n=3, stream 11,AA,BB,CC,DD ×3, all valid -> match_pulse at each DD; pattern_detected=1 one cycle after the third DD; frame_start on each following AA.
- Unaligned start and break: n=2, stream AA,AA,BB,CC,DD,AA,BB,CC,EE -> first match at the first DD; TRACK fails at EE; back to SEARCH with pattern_detected=0 throughout.
- Gap tolerance: n=2, two patterns with data_valid=0 for 5 cycles between the BB and CC of the second pattern -> lock is still reached; no pulses during the gap.
- Loss of lock: locked with MISS_MAX=2, send one corrupted period (AA,BB,CC,00) then a good one -> stays locked; then two corrupted periods -> pattern_detected=0 one cycle after the second period end.
- n=0, clear and reset:
  - n=0, a single pattern -> lock after the first occurrence.
  - clear asserted while LOCKED with data_valid=1 -> all outputs 0 next cycle.
  - RSTn asserted mid-TRACK -> outputs 0 immediately, without waiting for a clock edge.
- Feature enabled: 5 locked matched periods -> match_total=5. With the macro undefined, match_total stays 0.
